// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: holds all channel resets after power-up, system reset or a
// debounced manual press, then releases them one by one in index order with optional periodic re-reset.
module reset_sequencer #(
  parameter int          CHANNELS    = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned STAGE_GAP   = 256,
  parameter int          DEBOUNCE    = 16
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic                iManualN,
  input  logic [CNT_W-1:0]    iPeriod,
  output logic [CHANNELS-1:0] oRST_N,
  output logic                oDone,
  output logic [1:0]          oState
);

  localparam int REL_W = $clog2(CHANNELS + 1);
  localparam int DB_W  = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_STAGGER = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [REL_W-1:0]    rel_q, rel_d;
  logic [CHANNELS-1:0] rst_n_q, rst_n_d;
  logic                done_q, done_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                man_q, man_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;

  // One bit wider than cnt so the period compare never wraps.
  logic [CNT_W:0]      cnt_inc;
  logic [REL_W-1:0]    rel_inc;

  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign rel_inc = rel_q + REL_W'(1);

  // The debounced level flips only after DEBOUNCE consecutive differing samples.
  always_comb begin
    sync1_d  = iManualN;
    sync2_d  = sync1_q;
    man_d    = man_q;
    db_cnt_d = '0;
    if (sync2_q != man_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
        man_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    if (!man_q) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      rel_d   = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt_d   = '0;
            rel_d   = REL_W'(1);
            state_d = (CHANNELS == 1) ? S_RUN : S_STAGGER;
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        S_STAGGER: begin
          if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
            cnt_d = '0;
            rel_d = rel_inc;
            if (rel_inc == REL_W'(CHANNELS)) begin
              state_d = S_RUN;
            end
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        S_RUN: begin
          if (iPeriod == '0) begin
            cnt_d = '0;
          end else if (cnt_inc >= {1'b0, iPeriod}) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            rel_d   = '0;
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          rel_d   = '0;
        end
      endcase
    end
    done_d = (state_d == S_RUN);
    for (int k = 0; k < CHANNELS; k++) begin
      rst_n_d[k] = (int'(rel_d) > k);
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      rel_q    <= '0;
      rst_n_q  <= '0;
      done_q   <= 1'b0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      man_q    <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rel_q    <= rel_d;
      rst_n_q  <= rst_n_d;
      done_q   <= done_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      man_q    <= man_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign oRST_N = rst_n_q;
  assign oDone  = done_q;
  assign oState = state_q;

endmodule
